// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and payload type for the register-file write-port arbiter.
// Contents: register address/data widths, the r0 address, requester index
// assignments, and the writeback payload struct.
package regfile_wr_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Requester slots; lower index means higher base priority.
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MDU = 1;
  localparam int unsigned REQ_LD  = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_arb_aged_prio.sv
// Fixed-priority selector with an aged override.
// Ports:
//   valid    - per-requester request vector
//   wait_cnt - packed per-requester wait counters, slice i is [i*CNT_W +: CNT_W]
//   grant    - one-hot (or zero) grant, combinational
// Requesters whose counter has reached MAX_WAIT form the aged set; the lowest
// aged index wins, otherwise the lowest valid index wins.
module arb_aged_prio
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic [NUM_REQ-1:0]       valid,
  input  logic [NUM_REQ*CNT_W-1:0] wait_cnt,
  output logic [NUM_REQ-1:0]       grant
);

  logic [NUM_REQ-1:0] aged;
  logic [NUM_REQ-1:0] cand;

  // Aged set: valid requesters that have waited at least MAX_WAIT cycles.
  always_comb begin
    aged = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      aged[i] = valid[i] && (wait_cnt[i*CNT_W +: CNT_W] >= CNT_W'(MAX_WAIT));
    end
  end

  // Isolate the lowest set bit of the chosen candidate vector.
  always_comb begin
    cand  = (|aged) ? aged : valid;
    grant = cand & (~cand + NUM_REQ'(1));
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: shares one write port between NUM_REQ
// writeback sources (ALU, mult/div, load) using fixed priority with aging,
// and registers the winning write into a one-entry output stage.
// Ports:
//   clock, ctrl_reset           - rising-edge clock, async active-high reset
//   req_valid/req_reg/req_data  - per-requester write requests (packed slices)
//   req_ready                   - one-hot grant, combinational
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg - registered RF write port
//   stall_any                   - combinational, some valid requester not granted
// Optional: define REGFILE_WR_ARB_FWD_EN to add the read-bypass ports
//   fwd_readRegA/B, rf_readA/B (in) and fwd_dataA/B (out).
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                         clock,
  input  logic                         ctrl_reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_reg,
  input  logic [DATA_W*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0]        ctrl_writeReg,
  output logic [DATA_W-1:0]            data_writeReg,
  output logic                         stall_any
`ifdef REGFILE_WR_ARB_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0]        fwd_readRegA,
  input  logic [REG_ADDR_W-1:0]        fwd_readRegB,
  input  logic [DATA_W-1:0]            rf_readA,
  input  logic [DATA_W-1:0]            rf_readB,
  output logic [DATA_W-1:0]            fwd_dataA,
  output logic [DATA_W-1:0]            fwd_dataB
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Counters must be able to represent MAX_WAIT.
  if ((2 ** CNT_W) <= MAX_WAIT) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MAX_WAIT");
  end

  logic [NUM_REQ*CNT_W-1:0] wait_cnt_q;
  logic [NUM_REQ*CNT_W-1:0] wait_cnt_d;
  logic [NUM_REQ-1:0]       arb_grant;
  wb_req_t                  win;
  logic                     xfer;

  arb_aged_prio #(
    .NUM_REQ  (NUM_REQ),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_arb (
    .valid    (req_valid),
    .wait_cnt (wait_cnt_q),
    .grant    (arb_grant)
  );

  // Grants are suppressed while reset is held.
  always_comb begin
    req_ready = ctrl_reset ? '0 : arb_grant;
    stall_any = |(req_valid & ~req_ready);
    xfer      = |req_ready;
  end

  // Select the granted payload; grant is one-hot so at most one slice matches.
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        win.addr = req_reg[i*REG_ADDR_W +: REG_ADDR_W];
        win.data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Wait counters: clear when idle or granted, otherwise saturating increment.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] || req_ready[i]) begin
        wait_cnt_d[i*CNT_W +: CNT_W] = '0;
      end else if (wait_cnt_q[i*CNT_W +: CNT_W] != CNT_MAX) begin
        wait_cnt_d[i*CNT_W +: CNT_W] = wait_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Output stage: writes to r0 are accepted but never enabled.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= xfer && (win.addr != REG_ZERO);
      if (xfer) begin
        ctrl_writeReg <= win.addr;
        data_writeReg <= win.data;
      end
    end
  end

`ifdef REGFILE_WR_ARB_FWD_EN
  // Bypass the in-flight write to readers of the same (non-zero) register.
  always_comb begin
    fwd_dataA = rf_readA;
    fwd_dataB = rf_readB;
    if (ctrl_writeEnable && (ctrl_writeReg == fwd_readRegA) && (fwd_readRegA != REG_ZERO)) begin
      fwd_dataA = data_writeReg;
    end
    if (ctrl_writeEnable && (ctrl_writeReg == fwd_readRegB) && (fwd_readRegB != REG_ZERO)) begin
      fwd_dataB = data_writeReg;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the arbitration rules.
module tb_regfile_wr_arbiter;

  localparam int NREQ    = 3;
  localparam int MAXW    = 4;
  localparam int CNT_SAT = 7;

  logic        clock;
  logic        ctrl_reset;
  logic [2:0]  req_valid;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall_any;
`ifdef REGFILE_WR_ARB_FWD_EN
  logic [4:0]  fwd_readRegA, fwd_readRegB;
  logic [31:0] rf_readA, rf_readB, fwd_dataA, fwd_dataB;
`endif

  regfile_wr_arbiter dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .stall_any        (stall_any)
`ifdef REGFILE_WR_ARB_FWD_EN
    ,
    .fwd_readRegA     (fwd_readRegA),
    .fwd_readRegB     (fwd_readRegB),
    .rf_readA         (rf_readA),
    .rf_readB         (rf_readB),
    .fwd_dataA        (fwd_dataA),
    .fwd_dataB        (fwd_dataB)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Requester-side stimulus state.
  logic        v [NREQ];
  logic [4:0]  r [NREQ];
  logic [31:0] d [NREQ];

  // Reference model state.
  int          wcnt [NREQ];
  logic        exp_we;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  int          last_g;
  bit          in_reset;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = v[i];
      req_reg[i*5 +: 5]     = r[i];
      req_data[i*32 +: 32]  = d[i];
    end
  endtask

  // Winner by rule: oldest-waiting tier first, then plain priority order.
  function automatic int pick();
    int aged_q[$];
    int val_q[$];
    if (in_reset) return -1;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        val_q.push_back(i);
        if (wcnt[i] >= MAXW) aged_q.push_back(i);
      end
    end
    if (aged_q.size() > 0) return aged_q[0];
    if (val_q.size() > 0) return val_q[0];
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
    exp_we   = 1'b0;
    exp_reg  = '0;
    exp_data = '0;
    last_g   = -1;
  endtask

  // One clock cycle: check grant before the edge, outputs after it.
  task automatic cycle();
    int         g;
    logic [2:0] er;
    logic       es;
    apply();
    #1;
    g  = pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    es = 1'b0;
    for (int i = 0; i < NREQ; i++) if (v[i] && g != i) es = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    check("stall_any", 32'(stall_any), 32'(es));
    @(posedge clock);
    if (g >= 0) begin
      exp_we   = (r[g] != 5'd0);
      exp_reg  = r[g];
      exp_data = d[g];
    end else begin
      exp_we = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!v[i] || g == i) wcnt[i] = 0;
      else if (wcnt[i] < CNT_SAT) wcnt[i]++;
    end
    last_g = g;
    #1;
    check("writeEnable", 32'(ctrl_writeEnable), 32'(exp_we));
    check("writeReg", 32'(ctrl_writeReg), 32'(exp_reg));
    check("writeData", data_writeReg, exp_data);
  endtask

  task automatic idle_all();
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0;
      r[i] = '0;
      d[i] = '0;
    end
  endtask

  initial begin
    ctrl_reset = 1'b1;
    in_reset   = 1'b1;
    req_valid  = '0;
    req_reg    = '0;
    req_data   = '0;
`ifdef REGFILE_WR_ARB_FWD_EN
    fwd_readRegA = '0; fwd_readRegB = '0; rf_readA = '0; rf_readB = '0;
`endif
    idle_all();
    model_reset();

    // Reset state.
    @(posedge clock); @(posedge clock); #1;
    check("rst_we", 32'(ctrl_writeEnable), 32'd0);
    check("rst_reg", 32'(ctrl_writeReg), 32'd0);
    check("rst_data", data_writeReg, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    ctrl_reset = 1'b0;
    in_reset   = 1'b0;
    cycle();

    // Priority: requester 1 alone among 1 and 2 wins over 2.
    v[1] = 1'b1; r[1] = 5'd5; d[1] = 32'hDEADBEEF;
    v[2] = 1'b1; r[2] = 5'd6; d[2] = 32'h0000_0006;
    apply(); #1;
    check("prio_ready", 32'(req_ready), 32'b010);
    cycle();
    check("prio_we", 32'(ctrl_writeEnable), 32'd1);
    check("prio_reg", 32'(ctrl_writeReg), 32'd5);
    check("prio_data", data_writeReg, 32'hDEADBEEF);
    v[1] = 1'b0;
    cycle();
    idle_all();
    cycle();

    // r0 write is accepted and dropped.
    v[0] = 1'b1; r[0] = 5'd0; d[0] = 32'h1234;
    apply(); #1;
    check("r0_ready", 32'(req_ready), 32'b001);
    cycle();
    check("r0_we", 32'(ctrl_writeEnable), 32'd0);
    idle_all();
    cycle();

    // Same-target collision: 0xA then 0xB land on r7 in consecutive cycles.
    v[0] = 1'b1; r[0] = 5'd7; d[0] = 32'hA;
    v[1] = 1'b1; r[1] = 5'd7; d[1] = 32'hB;
    apply(); #1;
    check("coll_stall0", 32'(stall_any), 32'd1);
    cycle();
    check("coll_data0", data_writeReg, 32'hA);
    v[0] = 1'b0;
    apply(); #1;
    check("coll_stall1", 32'(stall_any), 32'd0);
    cycle();
    check("coll_we1", 32'(ctrl_writeEnable), 32'd1);
    check("coll_reg1", 32'(ctrl_writeReg), 32'd7);
    check("coll_data1", data_writeReg, 32'hB);
    idle_all();
    cycle();

    // Aging: requester 2 waits four cycles, wins on the fifth.
    for (int k = 1; k <= 6; k++) begin
      v[0] = 1'b1; r[0] = 5'(k); d[0] = 32'(k);
      v[2] = 1'b1; r[2] = 5'd20; d[2] = 32'h2020;
      apply(); #1;
      check("age_ready", 32'(req_ready), (k == 5) ? 32'b100 : 32'b001);
      cycle();
    end
    idle_all();
    cycle();

    // Reset mid-stream with all requesters active.
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b1; r[i] = 5'(i + 1); d[i] = 32'h100 + 32'(i);
    end
    repeat (3) cycle();
    ctrl_reset = 1'b1;
    in_reset   = 1'b1;
    model_reset();
    #1;
    check("mrst_we", 32'(ctrl_writeEnable), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    check("mrst_data", data_writeReg, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    ctrl_reset = 1'b0;
    in_reset   = 1'b0;
    apply(); #1;
    check("mrst_first", 32'(req_ready), 32'b001);
    repeat (8) cycle();
    idle_all();
    cycle();

`ifdef REGFILE_WR_ARB_FWD_EN
    // Forwarding of the in-flight write.
    v[0] = 1'b1; r[0] = 5'd9; d[0] = 32'h55;
    cycle();
    idle_all();
    apply();
    fwd_readRegA = 5'd9; rf_readA = 32'd0;
    #1;
    check("fwd_hit", fwd_dataA, 32'h55);
    fwd_readRegA = 5'd0; rf_readA = 32'hCAFE;
    #1;
    check("fwd_r0", fwd_dataA, 32'hCAFE);
    cycle();
`endif

    // Randomized traffic obeying the hold-until-transfer rule.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_g == i) v[i] = 1'b0;
        if (!v[i] && $urandom_range(0, 99) < 60) begin
          v[i] = 1'b1;
          r[i] = 5'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
